// File: rtl/otp_macro_seq_pkg.sv
// Shared types and helpers for the OTP macro request sequencer.
package otp_macro_seq_pkg;

    // Command and error encodings seen on the macro interface.
    typedef enum logic [2:0] {
        Read     = 3'h0,
        Write    = 3'h1,
        ReadRaw  = 3'h2,
        WriteRaw = 3'h3,
        Init     = 3'h4
    } cmd_e;

    typedef enum logic [2:0] {
        NoError              = 3'h0,
        MacroError           = 3'h1,
        MacroEccCorrError    = 3'h2,
        MacroEccUncorrError  = 3'h3,
        MacroWriteBlankError = 3'h4
    } err_e;

    // Sparse state codes so a single flipped bit never lands on another legal state.
    typedef enum logic [5:0] {
        ResetSt    = 6'b101001,
        InitReqSt  = 6'b010011,
        InitWaitSt = 6'b110110,
        IdleSt     = 6'b001110,
        IssueSt    = 6'b100101,
        WaitSt     = 6'b011000,
        ErrorSt    = 6'b111111
    } state_e;

    // Bits needed to hold values 0..value-1 (at least one bit).
    function automatic int vbits(int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    // Client write/raw bits to macro command.
    function automatic cmd_e cmd_sel(logic write, logic raw);
        cmd_e cmd;
        if (write) cmd = raw ? WriteRaw : Write;
        else       cmd = raw ? ReadRaw : Read;
        return cmd;
    endfunction

    function automatic logic is_read_cmd(cmd_e cmd);
        return (cmd == Read) || (cmd == ReadRaw);
    endfunction

endpackage

// File: rtl/otp_macro_seq_timer.sv
// Response timeout counter: cleared at the macro handshake, counts while waiting.
module otp_macro_seq_timer
    import otp_macro_seq_pkg::*;
#(
    parameter int Limit = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CntWidth = vbits(Limit + 1);
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(Limit - 1);
    localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(Limit);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    // Clear wins; otherwise count up while enabled and hold once Limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    // The enabled cycle that would make the count reach Limit is the expiry cycle.
    assign expired_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/otp_macro_req_seq.sv
// Sequences OTP macro commands: mandatory Init after reset, then one client request at a time.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ResetSt    | first cycle out of reset, nothing driven
// InitReqSt  | Init command presented to the macro
// InitWaitSt | waiting for the Init response
// IdleSt     | ready for a client request
// IssueSt    | client command presented to the macro
// WaitSt     | waiting for the macro response, timeout running
// ErrorSt    | terminal lockout, only reset leaves
module otp_macro_req_seq
    import otp_macro_seq_pkg::*;
#(
    parameter int Width         = 16,
    parameter int Depth         = 1024,
    parameter int SizeWidth     = 2,
    parameter int TimeoutCycles = 1024,
    localparam int AddrWidth    = vbits(Depth),
    localparam int IfWidth      = (2 ** SizeWidth) * Width
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output logic                 init_done_o,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic                 req_raw_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [SizeWidth-1:0] req_size_i,
    input  logic [IfWidth-1:0]   req_wdata_i,
    output logic                 rsp_valid_o,
    output logic [IfWidth-1:0]   rsp_rdata_o,
    output err_e                 rsp_err_o,
    output logic                 rsp_addr_err_o,
    output logic                 macro_valid_o,
    input  logic                 macro_ready_i,
    output cmd_e                 macro_cmd_o,
    output logic [SizeWidth-1:0] macro_size_o,
    output logic [AddrWidth-1:0] macro_addr_o,
    output logic [IfWidth-1:0]   macro_wdata_o,
    input  logic                 macro_rvalid_i,
    input  logic [IfWidth-1:0]   macro_rdata_i,
    input  err_e                 macro_err_i,
    output logic                 fatal_o
);

    localparam int EndWidth = AddrWidth + 1;
    localparam logic [EndWidth-1:0] LastAddr = EndWidth'(Depth - 1);

    state_e               state_q, state_d;
    cmd_e                 cmd_q, cmd_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [SizeWidth-1:0] size_q, size_d;
    logic [IfWidth-1:0]   wdata_q, wdata_d;
    logic [IfWidth-1:0]   rdata_q, rdata_d;
    err_e                 err_q, err_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 addr_err_q, addr_err_d;
    logic                 init_done_q, init_done_d;
    logic                 tmr_clr, tmr_en, tmr_expired;
    logic [EndWidth-1:0]  end_addr;
    logic                 range_err;

    // One bit wider than the address so a burst running past the top cannot wrap.
    assign end_addr  = {1'b0, req_addr_i} + EndWidth'(req_size_i);
    assign range_err = end_addr > LastAddr;

    otp_macro_seq_timer #(
        .Limit (TimeoutCycles)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    // Next-state, capture and response logic.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        addr_err_d  = 1'b0;
        init_done_d = init_done_q;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;

        unique case (state_q)
            ResetSt: state_d = InitReqSt;
            InitReqSt: begin
                if (macro_ready_i) state_d = InitWaitSt;
            end
            InitWaitSt: begin
                if (macro_rvalid_i) begin
                    if (macro_err_i == NoError) begin
                        state_d     = IdleSt;
                        init_done_d = 1'b1;
                    end else begin
                        state_d = ErrorSt;
                    end
                end
            end
            IdleSt: begin
                if (macro_rvalid_i) begin
                    state_d = ErrorSt;
                end else if (req_valid_i) begin
                    cmd_d   = cmd_sel(req_write_i, req_raw_i);
                    addr_d  = req_addr_i;
                    size_d  = req_size_i;
                    wdata_d = req_wdata_i;
                    if (range_err) begin
                        rsp_valid_d = 1'b1;
                        addr_err_d  = 1'b1;
                        err_d       = NoError;
                    end else begin
                        state_d = IssueSt;
                    end
                end
            end
            IssueSt: begin
                if (macro_rvalid_i) begin
                    state_d = ErrorSt;
                end else if (macro_ready_i) begin
                    state_d = WaitSt;
                    tmr_clr = 1'b1;
                end
            end
            WaitSt: begin
                tmr_en = 1'b1;
                if (macro_rvalid_i) begin
                    if (is_read_cmd(cmd_q)) rdata_d = macro_rdata_i;
                    err_d       = macro_err_i;
                    rsp_valid_d = 1'b1;
                    state_d     = IdleSt;
                end else if (tmr_expired) begin
                    // A silent macro is reported as uncorrectable so the client never trusts the data.
                    err_d       = MacroEccUncorrError;
                    rsp_valid_d = 1'b1;
                    state_d     = ErrorSt;
                end
            end
            ErrorSt: state_d = ErrorSt;
            default: state_d = ErrorSt;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ResetSt;
            cmd_q       <= Init;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= NoError;
            rsp_valid_q <= 1'b0;
            addr_err_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            addr_err_q  <= addr_err_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done_o    = init_done_q;
    assign req_ready_o    = (state_q == IdleSt);
    assign macro_valid_o  = (state_q == InitReqSt) || (state_q == IssueSt);
    assign fatal_o        = (state_q == ErrorSt);
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_rdata_o    = rdata_q;
    assign rsp_err_o      = err_q;
    assign rsp_addr_err_o = addr_err_q;
    assign macro_cmd_o    = cmd_q;
    assign macro_size_o   = size_q;
    assign macro_addr_o   = addr_q;
    assign macro_wdata_o  = wdata_q;

endmodule

// File: tb/tb_otp_macro_req_seq.sv
// Randomised scoreboard bench for otp_macro_req_seq; the bench plays both client and macro.
module tb_otp_macro_req_seq;
    import otp_macro_seq_pkg::*;

    localparam int W  = 16;
    localparam int D  = 1024;
    localparam int SW = 2;
    localparam int TO = 1024;
    localparam int AW = 10;
    localparam int IW = 64;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          init_done_o;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_write_i = 1'b0;
    logic          req_raw_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [SW-1:0] req_size_i = '0;
    logic [IW-1:0] req_wdata_i = '0;
    logic          rsp_valid_o;
    logic [IW-1:0] rsp_rdata_o;
    err_e          rsp_err_o;
    logic          rsp_addr_err_o;
    logic          macro_valid_o;
    logic          macro_ready_i = 1'b0;
    cmd_e          macro_cmd_o;
    logic [SW-1:0] macro_size_o;
    logic [AW-1:0] macro_addr_o;
    logic [IW-1:0] macro_wdata_o;
    logic          macro_rvalid_i = 1'b0;
    logic [IW-1:0] macro_rdata_i = '0;
    err_e          macro_err_i = NoError;
    logic          fatal_o;

    otp_macro_req_seq #(
        .Width (W), .Depth (D), .SizeWidth (SW), .TimeoutCycles (TO)
    ) dut (
        .clk_i (clk_i), .rst_ni (rst_ni), .init_done_o (init_done_o),
        .req_valid_i (req_valid_i), .req_ready_o (req_ready_o),
        .req_write_i (req_write_i), .req_raw_i (req_raw_i),
        .req_addr_i (req_addr_i), .req_size_i (req_size_i), .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o), .rsp_rdata_o (rsp_rdata_o), .rsp_err_o (rsp_err_o),
        .rsp_addr_err_o (rsp_addr_err_o),
        .macro_valid_o (macro_valid_o), .macro_ready_i (macro_ready_i),
        .macro_cmd_o (macro_cmd_o), .macro_size_o (macro_size_o),
        .macro_addr_o (macro_addr_o), .macro_wdata_o (macro_wdata_o),
        .macro_rvalid_i (macro_rvalid_i), .macro_rdata_i (macro_rdata_i),
        .macro_err_i (macro_err_i), .fatal_o (fatal_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [IW-1:0] rdata;
        err_e          err;
        logic          addr_err;
        int            due;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Reference model: macro contents and the last data handed back to the client.
    logic [W-1:0]  mem [D];
    logic [IW-1:0] last_rdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    exp_t mon_e;
    always @(negedge clk_i) begin
        if (rst_ni && rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rsp: actual=rsp_valid required=none (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata_o, mon_e.rdata);
                check("rsp_err", 64'(rsp_err_o), 64'(mon_e.err));
                check("rsp_addr_err", 64'(rsp_addr_err_o), 64'(mon_e.addr_err));
                check("rsp_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    task automatic reset_and_init(input err_e init_err);
        int   k;
        logic seen;
        rst_ni = 1'b0;
        req_valid_i = 1'b0;
        macro_ready_i = 1'b0;
        macro_rvalid_i = 1'b0;
        macro_err_i = NoError;
        tick();
        check("rst_init_done", 64'(init_done_o), 0);
        check("rst_req_ready", 64'(req_ready_o), 0);
        check("rst_rsp_valid", 64'(rsp_valid_o), 0);
        check("rst_rsp_rdata", rsp_rdata_o, 0);
        check("rst_rsp_err", 64'(rsp_err_o), 64'(NoError));
        check("rst_macro_valid", 64'(macro_valid_o), 0);
        check("rst_macro_cmd", 64'(macro_cmd_o), 64'(Init));
        check("rst_macro_addr", 64'(macro_addr_o), 0);
        check("rst_fatal", 64'(fatal_o), 0);
        exp_q.delete();
        last_rdata = '0;
        tick();
        rst_ni = 1'b1;
        macro_ready_i = 1'b1;
        seen = 1'b0;
        for (k = 0; k < 8; k++) begin
            tick();
            if (macro_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        check("init_req_seen", 64'(seen), 1);
        check("init_cmd", 64'(macro_cmd_o), 64'(Init));
        tick();
        macro_ready_i = 1'b0;
        check("init_single_handshake", 64'(macro_valid_o), 0);
        tick();
        tick();
        macro_rvalid_i = 1'b1;
        macro_err_i = init_err;
        tick();
        macro_rvalid_i = 1'b0;
        macro_err_i = NoError;
        if (init_err == NoError) begin
            check("init_done", 64'(init_done_o), 1);
            check("init_req_ready", 64'(req_ready_o), 1);
            check("init_fatal", 64'(fatal_o), 0);
        end else begin
            check("init_fail_fatal", 64'(fatal_o), 1);
            check("init_fail_done", 64'(init_done_o), 0);
            check("init_fail_ready", 64'(req_ready_o), 0);
            tick();
            check("init_fail_macro_valid", 64'(macro_valid_o), 0);
        end
    endtask

    // One client transaction; returns in the cycle the response pulse is due so the
    // next call exercises back-to-back acceptance.
    task automatic transact(input logic write, input logic raw, input int addr, input int size,
                            input logic [IW-1:0] wdata, input err_e merr,
                            input int rdy_dly, input int rsp_dly);
        int            c;
        cmd_e          exp_cmd;
        logic [IW-1:0] rd;
        exp_t          e;
        exp_cmd = write ? (raw ? WriteRaw : Write) : (raw ? ReadRaw : Read);
        req_valid_i = 1'b1;
        req_write_i = write;
        req_raw_i = raw;
        req_addr_i = AW'(addr);
        req_size_i = SW'(size);
        req_wdata_i = wdata;
        check("req_ready", 64'(req_ready_o), 1);
        c = cyc;
        tick();
        req_valid_i = 1'b0;
        req_addr_i = AW'($urandom);
        req_size_i = SW'($urandom);
        req_wdata_i = {$urandom, $urandom};
        if (addr + size > D - 1) begin
            e.rdata = last_rdata; e.err = NoError; e.addr_err = 1'b1; e.due = c + 1;
            exp_q.push_back(e);
            check("range_no_macro_valid", 64'(macro_valid_o), 0);
            return;
        end
        check("macro_valid_latency", 64'(macro_valid_o), 1);
        check("macro_cmd", 64'(macro_cmd_o), 64'(exp_cmd));
        check("macro_addr", 64'(macro_addr_o), 64'(addr));
        check("macro_size", 64'(macro_size_o), 64'(size));
        check("macro_wdata", macro_wdata_o, wdata);
        for (int k = 0; k < rdy_dly; k++) begin
            tick();
            if (!macro_valid_o || macro_cmd_o != exp_cmd)
                check("macro_hold", {63'd0, macro_valid_o}, 64'd1);
        end
        macro_ready_i = 1'b1;
        tick();
        macro_ready_i = 1'b0;
        for (int k = 0; k < rsp_dly; k++) tick();
        rd = '0;
        if (!write) begin
            for (int i = 0; i <= size; i++) rd[i*W +: W] = mem[addr + i];
            macro_rdata_i = rd;
            last_rdata = rd;
        end else begin
            for (int i = 0; i <= size; i++) mem[addr + i] = wdata[i*W +: W];
            macro_rdata_i = {$urandom, $urandom};
        end
        macro_rvalid_i = 1'b1;
        macro_err_i = merr;
        e.rdata = last_rdata; e.err = merr; e.addr_err = 1'b0; e.due = cyc + 1;
        exp_q.push_back(e);
        tick();
        macro_rvalid_i = 1'b0;
        macro_err_i = NoError;
        check("nonfatal_err", 64'(fatal_o), 0);
    endtask

    err_e errs [4] = '{NoError, MacroEccCorrError, MacroEccUncorrError, MacroWriteBlankError};

    initial begin
        int n;
        for (int i = 0; i < D; i++) mem[i] = W'($urandom);

        reset_and_init(NoError);

        mem[16] = 16'h0001; mem[17] = 16'h0002; mem[18] = 16'h0003; mem[19] = 16'h0004;
        transact(1'b0, 1'b0, 'h10, 3, 64'h0, NoError, 0, 2);
        check("directed_read_model", last_rdata, 64'h0004_0003_0002_0001);
        transact(1'b1, 1'b1, 'h20, 1, 64'h1234_5678_9abc_def0, MacroWriteBlankError, 1, 3);
        transact(1'b0, 1'b0, D - 2, 3, 64'h0, NoError, 0, 0);
        transact(1'b0, 1'b0, D - 4, 3, 64'h0, MacroEccCorrError, 0, 0);

        for (int t = 0; t < 60; t++) begin
            int a;
            a = ($urandom_range(0, 3) == 0) ? D - 1 - int'($urandom_range(0, 4))
                                            : int'($urandom_range(0, D - 1));
            transact(1'($urandom), 1'($urandom), a, int'($urandom_range(0, 3)),
                     {$urandom, $urandom}, errs[$urandom_range(0, 3)],
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        end
        tick();
        tick();
        check("queue_drained_random", 64'(exp_q.size()), 0);

        // Read that the macro never answers.
        req_valid_i = 1'b1; req_write_i = 1'b0; req_raw_i = 1'b0;
        req_addr_i = AW'(5); req_size_i = SW'(0);
        tick();
        req_valid_i = 1'b0;
        macro_ready_i = 1'b1;
        tick();
        macro_ready_i = 1'b0;
        begin
            exp_t e;
            e.rdata = last_rdata; e.err = MacroEccUncorrError; e.addr_err = 1'b0; e.due = cyc + TO;
            exp_q.push_back(e);
        end
        n = 0;
        for (int k = 0; k < TO + 50; k++) begin
            if (fatal_o) break;
            n++;
            tick();
        end
        check("timeout_cycles", 64'(n), 64'(TO));
        req_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("locked_req_ready", 64'(req_ready_o), 0);
            check("locked_macro_valid", 64'(macro_valid_o), 0);
        end
        req_valid_i = 1'b0;
        check("locked_fatal", 64'(fatal_o), 1);
        check("queue_drained_timeout", 64'(exp_q.size()), 0);

        // Reset re-issues Init, then a stray macro response in IdleSt.
        reset_and_init(NoError);
        transact(1'b1, 1'b0, 'h30, 2, {$urandom, $urandom}, NoError, 0, 1);
        transact(1'b0, 1'b0, 'h30, 2, 64'h0, NoError, 2, 0);
        tick();
        tick();
        macro_rvalid_i = 1'b1;
        tick();
        macro_rvalid_i = 1'b0;
        check("proto_fatal", 64'(fatal_o), 1);
        check("proto_init_done_kept", 64'(init_done_o), 1);
        check("proto_req_ready", 64'(req_ready_o), 0);
        check("queue_drained_proto", 64'(exp_q.size()), 0);

        reset_and_init(MacroEccUncorrError);
        reset_and_init(NoError);
        transact(1'b0, 1'b1, 'h3FC, 3, 64'h0, NoError, 1, 1);
        transact(1'b0, 1'b1, 'h3FD, 3, 64'h0, NoError, 0, 0);
        transact(1'b1, 1'b0, 'h100, 0, {$urandom, $urandom}, MacroError, 0, 2);
        tick();
        tick();
        check("queue_drained_final", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard stop in case the flow above stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/otp_macro_req_seq.md
Name: otp_macro_req_seq

Overview:
Command sequencer that sits directly upstream of the OTP macro emulation wrapper. After reset it issues the mandatory Init command, then converts single client requests (read/write, ECC or raw) into macro ready/valid transactions. It captures the macro response and returns it to the client as a registered one-cycle response. It also provides address-range rejection, a response timeout and a fatal-error lockout.

Parameters:
Width, 16, native OTP word width in bits
Depth, 1024, macro depth in native words; AddrWidth = vbits(Depth)
SizeWidth, 2, size field width; IfWidth = 2**SizeWidth*Width
TimeoutCycles, 1024, max cycles from macro handshake to macro response; counter width vbits(TimeoutCycles+1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
init_done_o  out  1  macro initialised, sequencer operational
req_valid_i  in  1  client request valid
req_ready_o  out  1  client request accepted when valid&&ready
req_write_i  in  1  1=write, 0=read
req_raw_i  in  1  1=raw (no ECC) command variant
req_addr_i  in  AddrWidth  start native-word address
req_size_i  in  SizeWidth  number of words minus 1
req_wdata_i  in  IfWidth  write data
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  IfWidth  read data, held until next response
rsp_err_o  out  err_e  macro error code
rsp_addr_err_o  out  1  request rejected for range violation
macro_valid_o  out  1  command valid to macro
macro_ready_i  in  1  macro ready
macro_cmd_o  out  cmd_e  Init/Read/Write/ReadRaw/WriteRaw
macro_size_o  out  SizeWidth  captured size
macro_addr_o  out  AddrWidth  captured address
macro_wdata_o  out  IfWidth  captured write data
macro_rvalid_i  in  1  macro response valid
macro_rdata_i  in  IfWidth  macro read data
macro_err_i  in  err_e  macro error
fatal_o  out  1  sticky fatal (timeout, protocol or init failure)

Behaviour:
- Reset: all outputs 0; macro_cmd_o=Init; rsp_err_o=NoError; FSM in ResetSt.
- FSM states: ResetSt, InitReqSt, InitWaitSt, IdleSt, IssueSt, WaitSt, ErrorSt. Use sparse encoding; any illegal state goes to ErrorSt.
- ResetSt -> InitReqSt unconditionally on the next cycle.
- InitReqSt: macro_valid_o=1, cmd=Init. When macro_ready_i=1 -> InitWaitSt.
- InitWaitSt: on macro_rvalid_i:
  - err==NoError -> IdleSt, init_done_o=1 (sticky).
  - otherwise -> ErrorSt.
- IdleSt: req_ready_o=1. On handshake, register addr/size/wdata and cmd. cmd = Read, Write, ReadRaw or WriteRaw from write/raw bits.
  - If addr+size > Depth-1 (compute in AddrWidth+1 bits), stay in IdleSt. Next cycle: rsp_valid_o=1, rsp_addr_err_o=1, rsp_err_o=NoError, rdata unchanged. No macro command is issued.
  - Otherwise -> IssueSt.
- IssueSt: macro_valid_o=1; outputs held stable until macro_ready_i. On handshake -> WaitSt, clear timeout counter.
- WaitSt: counter increments each cycle.
  - On macro_rvalid_i: capture rdata (reads only; writes leave rdata unchanged) and macro_err_i. Next cycle rsp_valid_o=1 -> IdleSt.
  - Correctable, uncorrectable and blank errors are reported via rsp_err_o and are not fatal.
  - If the counter reaches TimeoutCycles with no response -> ErrorSt, rsp_valid_o=1 and rsp_err_o=MacroEccUncorrError in the same transition.
- Latency: accept at cycle 0, macro_valid_o at cycle 1. A macro response at cycle N gives rsp_valid_o at cycle N+1.
- Protocol error: macro_rvalid_i=1 in IdleSt or IssueSt -> ErrorSt.
- ErrorSt: terminal. fatal_o=1, req_ready_o=0, macro_valid_o=0, init_done_o keeps its value. Only rst_ni exits.
- Back-to-back: a new request is accepted in the cycle rsp_valid_o is asserted, because the FSM is already in IdleSt.
- Reset mid-operation clears everything asynchronously; Init is re-issued after reset.

Decomposition:
- Shared package otp_macro_seq_pkg holds the state encoding typedef and the cmd-select helper function.
- cmd_e and err_e come from the existing prim OTP package.
- One sub-module, otp_macro_seq_timer: a loadable timeout counter with clear, enable and expired outputs.

Test Plan:
- Reset release, macro ready=1, Init response NoError after 3 cycles -> one Init handshake, init_done_o=1, req_ready_o=1 next cycle.
- Read addr=0x10, size=3, macro returns rdata=0x0004_0003_0002_0001 with NoError -> rsp_valid_o one cycle later with that rdata, err=NoError.
- WriteRaw addr=0x20, macro returns MacroWriteBlankError -> rsp_err_o=MacroWriteBlankError, fatal_o=0, next request accepted.
- Read addr=Depth-2, size=3 -> no macro_valid_o; rsp_valid_o with rsp_addr_err_o=1 the next cycle.
- Read issued, macro never responds -> after exactly TimeoutCycles cycles fatal_o=1, rsp_valid_o pulse, req_ready_o=0 permanently.
- macro_rvalid_i pulsed in IdleSt, or Init response MacroEccUncorrError -> fatal_o=1; assert rst_ni -> Init re-issued.
